data_mem_stage: RTL

Memory-access stage of the 64-bit pipeline, between the EX/Mem register and the Mem/WB register. Turns load/store control and the EX/Mem ALU result (the address) into a request/acknowledge transaction on the data-memory bus. Handles byte/half/word/double sizing with lane steering and sign/zero extension, and delivers `Read_Data` to Mem/WB. Holds the pipeline with `Mem_Stall` until the memory acknowledges.

---
 rtl/mem_stage_pkg.sv | 48 ++++
 rtl/load_align.sv | 29 ++
 rtl/data_mem_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory-access stage: funct3 access codes, FSM
// state encoding, byte-lane masks and small sizing helpers.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access size is funct3[1:0]; the code 111 lands on the doubleword size.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [7:0] SIZE_MASK_B = 8'h01;
    localparam logic [7:0] SIZE_MASK_H = 8'h03;
    localparam logic [7:0] SIZE_MASK_W = 8'h0F;
    localparam logic [7:0] SIZE_MASK_D = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_mask = SIZE_MASK_B;
            SZ_H:    size_mask = SIZE_MASK_H;
            SZ_W:    size_mask = SIZE_MASK_W;
            default: size_mask = SIZE_MASK_D;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] sz, input logic [2:0] off);
        case (sz)
            SZ_B:    is_aligned = 1'b1;
            SZ_H:    is_aligned = (off[0] == 1'b0);
            SZ_W:    is_aligned = (off[1:0] == 2'b00);
            default: is_aligned = (off == 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data path: picks the addressed lane out of an aligned doubleword and
// sign- or zero-extends it according to funct3.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [63:0] dmem_rdata,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    output logic [63:0] ext_data
);

    logic [63:0] w_shifted;

    assign w_shifted = dmem_rdata >> {off, 3'b000};

    always_comb begin
        ext_data = w_shifted;
        case (funct3)
            F3_B:    ext_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            F3_H:    ext_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    ext_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            F3_BU:   ext_data = {56'd0, w_shifted[7:0]};
            F3_HU:   ext_data = {48'd0, w_shifted[15:0]};
            F3_WU:   ext_data = {32'd0, w_shifted[31:0]};
            default: ext_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_stage.sv
// Memory-access stage: converts EX/Mem load/store control into a req/ack
// transaction on the data bus and stalls the pipeline until it completes.
module data_mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        EX_Mem_MemRead,
    input  logic        EX_Mem_MemWrite,
    input  logic [2:0]  EX_Mem_funct3,
    input  logic [63:0] EX_Mem_ALU_Rslt,
    input  logic [63:0] EX_Mem_Write_Data,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic [63:0] Read_Data,
    output logic        Mem_Stall,
    output logic        Mem_Misalign,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_be
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_req;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_be;
    logic [63:0] r_read_data;
    logic [2:0]  r_off;
    logic [2:0]  r_funct3;

    logic        w_access;
    logic        w_aligned;
    logic        w_start;
    logic        w_misalign;
    logic [1:0]  w_size;
    logic [2:0]  w_off;
    logic [63:0] w_load_data;

    assign w_size = EX_Mem_funct3[1:0];
    assign w_off  = EX_Mem_ALU_Rslt[2:0];

    always_comb begin
        w_access     = EX_Mem_MemRead | EX_Mem_MemWrite;
        w_aligned    = is_aligned(w_size, w_off);
        w_start      = 1'b0;
        w_misalign   = 1'b0;
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                w_start    = w_access & w_aligned;
                w_misalign = w_access & ~w_aligned;
                if (w_start) w_state_next = ST_REQ;
            end
            ST_REQ:  if (dmem_ack) w_state_next = ST_DONE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The stall must drop while reset is asserted so a frozen pipeline is released.
    assign Mem_Stall    = ~reset & (w_start | (r_state == ST_REQ));
    assign Mem_Misalign = ~reset & w_misalign;

    // Lane and extension info are taken from registered copies so the data
    // path does not depend on EX/Mem staying frozen.
    load_align u_load_align (
        .dmem_rdata (dmem_rdata),
        .off        (r_off),
        .funct3     (r_funct3),
        .ext_data   (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 64'd0;
            r_wdata     <= 64'd0;
            r_be        <= 8'd0;
            r_read_data <= 64'd0;
            r_off       <= 3'd0;
            r_funct3    <= 3'd0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_req    <= 1'b1;
                r_we     <= EX_Mem_MemWrite & ~EX_Mem_MemRead;
                r_addr   <= {EX_Mem_ALU_Rslt[63:3], 3'b000};
                r_wdata  <= EX_Mem_Write_Data << {w_off, 3'b000};
                r_be     <= size_mask(w_size) << w_off;
                r_off    <= w_off;
                r_funct3 <= EX_Mem_funct3;
            end
            if ((r_state == ST_REQ) && dmem_ack) begin
                r_req <= 1'b0;
                if (!r_we) r_read_data <= w_load_data;
            end
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;
    assign Read_Data  = r_read_data;

endmodule
